// File: rtl/stq_pkg.sv
// ---------------------------------------------------------------------------
// stq_pkg
// Shared sizing and types for the store-queue entry lifecycle controller.
//   BUF_COUNT  : number of store-queue entries (power of two)
//   PTR_W      : log2(BUF_COUNT); ring pointers carry one extra wrap bit
//   stq_ptr_t  : wrapped ring pointer / occupancy count (PTR_W+1 bits)
//   stq_vec_t  : one bit per store-queue entry
//   stq_onehot : decode an entry index into a per-entry strobe vector
// ---------------------------------------------------------------------------
package stq_pkg;

  localparam int BUF_COUNT = 64;
  localparam int PTR_W     = 6;

  typedef logic [PTR_W:0]       stq_ptr_t;
  typedef logic [BUF_COUNT-1:0] stq_vec_t;

  function automatic stq_vec_t stq_onehot(input logic [PTR_W-1:0] idx);
    stq_vec_t vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/stq_range_mask.sv
// ---------------------------------------------------------------------------
// stq_range_mask
// Expands a half-open ring interval [lo, hi) of wrapped pointers into a
// per-entry mask. A span equal to BUF_COUNT (lo and hi differ only in the
// wrap bit) selects every entry; lo == hi selects none.
// Ports:
//   lo   in  stq_ptr_t  first pointer of the interval (inclusive)
//   hi   in  stq_ptr_t  end pointer of the interval (exclusive)
//   mask out stq_vec_t  bit i set when entry i lies in [lo, hi)
// ---------------------------------------------------------------------------
module stq_range_mask
  import stq_pkg::*;
(
  input  stq_ptr_t lo,
  input  stq_ptr_t hi,
  output stq_vec_t mask
);

  stq_ptr_t span_s;

  // Entry i is inside the interval when its ring distance from lo is below the span.
  always_comb begin
    span_s = hi - lo;
    mask   = '0;
    for (int i = 0; i < BUF_COUNT; i++) begin
      mask[i] = ({1'b0, PTR_W'(i) - lo[PTR_W-1:0]} < span_s);
    end
  end

endmodule

// File: rtl/stq_alloc_ctl.sv
// ---------------------------------------------------------------------------
// stq_alloc_ctl
// Store-queue entry lifecycle controller. Three ring pointers partition the
// queue: [head, rptr) holds retired stores waiting to drain to the cache,
// [rptr, tail) holds allocated stores not yet retired.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alloc0_req, alloc1_req   request one / two entries (alloc1 only with alloc0)
//   alloc_ok                 enough free entries for the request, low on excpt
//   alloc0_idx, alloc1_idx   granted indices tail, tail+1
//   retire_cnt               stores retiring this cycle (0..2)
//   passe_en                 strobe for entries retiring this cycle
//   drain_valid, drain_idx   oldest retired store offered to the cache
//   drain_ack                cache accepted the offered store
//   free_en                  strobe for entries freed by drain or flush
//   excpt                    flush every unretired entry
//   count, full, empty       occupancy (tail - head) and its extremes
// ---------------------------------------------------------------------------
module stq_alloc_ctl
  import stq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc0_req,
  input  logic             alloc1_req,
  output logic             alloc_ok,
  output logic [PTR_W-1:0] alloc0_idx,
  output logic [PTR_W-1:0] alloc1_idx,
  input  logic [1:0]       retire_cnt,
  output stq_vec_t         passe_en,
  output logic             drain_valid,
  output logic [PTR_W-1:0] drain_idx,
  input  logic             drain_ack,
  output stq_vec_t         free_en,
  input  logic             excpt,
  output stq_ptr_t         count,
  output logic             full,
  output logic             empty
);

  stq_ptr_t   head_r;
  stq_ptr_t   rptr_r;
  stq_ptr_t   tail_r;
  stq_ptr_t   rptr_nxt_s;
  stq_ptr_t   tail_nxt_s;
  stq_ptr_t   free_cnt_s;
  logic [1:0] alloc_n_s;
  logic       drain_fire_s;
  stq_vec_t   passe_hot_s;
  stq_vec_t   drain_hot_s;
  stq_vec_t   flush_mask_s;

  // Flush reclaims everything still unretired after this cycle's retirement.
  stq_range_mask u_flush_mask (
    .lo   (rptr_nxt_s),
    .hi   (tail_r),
    .mask (flush_mask_s)
  );

  // Occupancy, allocation grant and index outputs.
  always_comb begin
    alloc_n_s  = {1'b0, alloc0_req} + {1'b0, alloc1_req};
    count      = tail_r - head_r;
    free_cnt_s = stq_ptr_t'(BUF_COUNT) - count;
    // Grant uses the pre-edge count: a drain in the same cycle gives no credit.
    alloc_ok   = (free_cnt_s >= {{(PTR_W-1){1'b0}}, alloc_n_s}) & ~excpt;
    alloc0_idx = tail_r[PTR_W-1:0];
    alloc1_idx = tail_r[PTR_W-1:0] + PTR_W'(1'b1);
    full       = (count == stq_ptr_t'(BUF_COUNT));
    empty      = (count == stq_ptr_t'(1'b0));
  end

  // Retire decode: up to two consecutive entries starting at rptr.
  always_comb begin
    rptr_nxt_s = rptr_r + {{(PTR_W-1){1'b0}}, retire_cnt};
    case (retire_cnt)
      2'd0:    passe_hot_s = '0;
      2'd1:    passe_hot_s = stq_onehot(rptr_r[PTR_W-1:0]);
      2'd2:    passe_hot_s = stq_onehot(rptr_r[PTR_W-1:0])
                           | stq_onehot(rptr_r[PTR_W-1:0] + PTR_W'(1'b1));
      default: passe_hot_s = '0;
    endcase
  end

  // Drain handshake and the combined free strobe (drain and flush bits are disjoint).
  always_comb begin
    drain_valid  = (head_r != rptr_r);
    drain_idx    = head_r[PTR_W-1:0];
    drain_fire_s = drain_valid & drain_ack;
    if (drain_fire_s) begin
      drain_hot_s = stq_onehot(head_r[PTR_W-1:0]);
    end else begin
      drain_hot_s = '0;
    end
    // No strobes while in reset: the array is resetting itself on the same edge.
    if (rst) begin
      passe_en = '0;
      free_en  = '0;
    end else if (excpt) begin
      passe_en = passe_hot_s;
      free_en  = drain_hot_s | flush_mask_s;
    end else begin
      passe_en = passe_hot_s;
      free_en  = drain_hot_s;
    end
  end

  // Next tail: flush rewinds it to the post-retire rptr, otherwise a grant advances it.
  always_comb begin
    if (excpt) begin
      tail_nxt_s = rptr_nxt_s;
    end else if (alloc_ok) begin
      tail_nxt_s = tail_r + {{(PTR_W-1){1'b0}}, alloc_n_s};
    end else begin
      tail_nxt_s = tail_r;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      rptr_r <= '0;
      tail_r <= '0;
    end else begin
      head_r <= head_r + {{PTR_W{1'b0}}, drain_fire_s};
      rptr_r <= rptr_nxt_s;
      tail_r <= tail_nxt_s;
    end
  end

endmodule

// File: tb/tb_stq_alloc_ctl.sv
// ---------------------------------------------------------------------------
// tb_stq_alloc_ctl
// Self-checking bench: a model built on unbounded integer pointers predicts
// every output each cycle; predictions go through a scoreboard queue and are
// compared at the falling edge. Directed constant checks follow the key
// scenarios, then a random legal phase runs.
// ---------------------------------------------------------------------------
module tb_stq_alloc_ctl;
  import stq_pkg::*;

  logic             clk;
  logic             rst;
  logic             alloc0_req;
  logic             alloc1_req;
  logic             alloc_ok;
  logic [PTR_W-1:0] alloc0_idx;
  logic [PTR_W-1:0] alloc1_idx;
  logic [1:0]       retire_cnt;
  stq_vec_t         passe_en;
  logic             drain_valid;
  logic [PTR_W-1:0] drain_idx;
  logic             drain_ack;
  stq_vec_t         free_en;
  logic             excpt;
  stq_ptr_t         count;
  logic             full;
  logic             empty;

  stq_alloc_ctl dut (
    .clk         (clk),
    .rst         (rst),
    .alloc0_req  (alloc0_req),
    .alloc1_req  (alloc1_req),
    .alloc_ok    (alloc_ok),
    .alloc0_idx  (alloc0_idx),
    .alloc1_idx  (alloc1_idx),
    .retire_cnt  (retire_cnt),
    .passe_en    (passe_en),
    .drain_valid (drain_valid),
    .drain_idx   (drain_idx),
    .drain_ack   (drain_ack),
    .free_en     (free_en),
    .excpt       (excpt),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             ok;
    logic [PTR_W-1:0] i0;
    logic [PTR_W-1:0] i1;
    stq_vec_t         passe;
    logic             dv;
    logic [PTR_W-1:0] di;
    stq_vec_t         free;
    stq_ptr_t         cnt;
    logic             full;
    logic             empty;
  } exp_t;

  exp_t sb[$];
  exp_t obs;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_head = 0;
  int   m_rptr = 0;
  int   m_tail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t predict(input logic a0, input logic a1, input logic [1:0] rc,
                                   input logic ack, input logic ex, input logic r);
    exp_t e;
    int   occ;
    int   n;
    occ     = m_tail - m_head;
    n       = int'(a0) + int'(a1);
    e.cnt   = 7'(occ);
    e.ok    = ((BUF_COUNT - occ) >= n) && !ex;
    e.i0    = 6'(m_tail % BUF_COUNT);
    e.i1    = 6'((m_tail + 1) % BUF_COUNT);
    e.dv    = (m_head != m_rptr);
    e.di    = 6'(m_head % BUF_COUNT);
    e.full  = (occ == BUF_COUNT);
    e.empty = (occ == 0);
    e.passe = '0;
    e.free  = '0;
    if (!r) begin
      for (int k = 0; k < int'(rc); k++) e.passe[(m_rptr + k) % BUF_COUNT] = 1'b1;
      if (e.dv && ack) e.free[m_head % BUF_COUNT] = 1'b1;
      if (ex) begin
        for (int j = m_rptr + int'(rc); j < m_tail; j++) e.free[j % BUF_COUNT] = 1'b1;
      end
    end
    return e;
  endfunction

  // One cycle: drive, push prediction, compare at negedge, advance model at posedge.
  task automatic step(input logic a0, input logic a1, input logic [1:0] rc,
                      input logic ack, input logic ex, input logic r);
    exp_t e;
    exp_t w;
    int   rnew;
    assert (r || int'(rc) <= m_tail - m_rptr) else $error("illegal retire_cnt %0d", rc);
    alloc0_req = a0;
    alloc1_req = a1;
    retire_cnt = rc;
    drain_ack  = ack;
    excpt      = ex;
    rst        = r;
    e = predict(a0, a1, rc, ack, ex, r);
    sb.push_back(e);
    @(negedge clk);
    w = sb.pop_front();
    obs.ok    = alloc_ok;
    obs.i0    = alloc0_idx;
    obs.i1    = alloc1_idx;
    obs.passe = passe_en;
    obs.dv    = drain_valid;
    obs.di    = drain_idx;
    obs.free  = free_en;
    obs.cnt   = count;
    obs.full  = full;
    obs.empty = empty;
    chk("alloc_ok",    64'(obs.ok),    64'(w.ok));
    chk("alloc0_idx",  64'(obs.i0),    64'(w.i0));
    chk("alloc1_idx",  64'(obs.i1),    64'(w.i1));
    chk("passe_en",    obs.passe,      w.passe);
    chk("drain_valid", 64'(obs.dv),    64'(w.dv));
    chk("drain_idx",   64'(obs.di),    64'(w.di));
    chk("free_en",     obs.free,       w.free);
    chk("count",       64'(obs.cnt),   64'(w.cnt));
    chk("full",        64'(obs.full),  64'(w.full));
    chk("empty",       64'(obs.empty), 64'(w.empty));
    @(posedge clk);
    if (r) begin
      m_head = 0;
      m_rptr = 0;
      m_tail = 0;
    end else begin
      if (e.dv && ack) m_head++;
      rnew = m_rptr + int'(rc);
      if (ex) m_tail = rnew;
      else if (e.ok) m_tail += int'(a0) + int'(a1);
      m_rptr = rnew;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; alloc0_req = 1'b0; alloc1_req = 1'b0;
    retire_cnt = 2'd0; drain_ack = 1'b0; excpt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_empty", 64'(obs.empty), 64'd1);
    chk("rst_count", 64'(obs.cnt), 64'd0);
    chk("rst_ok", 64'(obs.ok), 64'd1);

    // Fill with paired allocations
    for (int k = 0; k < 32; k++) begin
      step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("fill_i0", 64'(obs.i0), 64'(2 * k));
      chk("fill_i1", 64'(obs.i1), 64'(2 * k + 1));
    end
    step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("full_ok", 64'(obs.ok), 64'd0);
    chk("full_flag", 64'(obs.full), 64'd1);
    chk("full_count", 64'(obs.cnt), 64'd64);

    // Retire, hold drain, then drain 0..3
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("retire_passe", obs.passe, 64'h3);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
      chk("hold_idx", 64'(obs.di), 64'd0);
      chk("hold_valid", 64'(obs.dv), 64'd1);
    end
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("drain0_free", obs.free, 64'h1);
    step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    chk("drain_count", 64'(obs.cnt), 64'd63);
    chk("drain1_free", obs.free, 64'h2);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("drain3_free", obs.free, 64'h8);
    // Wrap
    step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_i0", 64'(obs.i0), 64'd0);
    chk("wrap_i1", 64'(obs.i1), 64'd1);
    chk("wrap_ok", 64'(obs.ok), 64'd1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_count", 64'(obs.cnt), 64'd62);
    chk("wrap_full", 64'(obs.full), 64'd0);

    // Flush: tail=10, rptr=4, head=2, retire one in the flush cycle
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (5) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0);
    chk("flush_passe", obs.passe, 64'h10);
    chk("flush_free", obs.free, 64'h3E0);
    chk("flush_ok", 64'(obs.ok), 64'd0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("post_flush_idx", 64'(obs.di), 64'd2);
    chk("post_flush_cnt", 64'(obs.cnt), 64'd3);

    // Flush with drain in the same cycle
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("flush_drain_free", obs.free, 64'h34);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_drain_cnt", 64'(obs.cnt), 64'd1);
    chk("flush_drain_idx", 64'(obs.di), 64'd3);

    // Reset mid-operation
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    repeat (10) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_free", obs.free, 64'h0);
    chk("rst_mid_passe", obs.passe, 64'h0);
    chk("rst_mid_cnt", 64'(obs.cnt), 64'd20);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("rst_after_cnt", 64'(obs.cnt), 64'd0);
    chk("rst_after_empty", 64'(obs.empty), 64'd1);
    chk("rst_after_free", obs.free, 64'h0);

    // Random legal traffic
    for (int c = 0; c < 400; c++) begin
      logic       a0;
      logic       a1;
      logic [1:0] rc;
      int         avail;
      a0    = 1'($urandom_range(0, 3) != 0);
      a1    = a0 & 1'($urandom_range(0, 1));
      avail = m_tail - m_rptr;
      rc    = 2'($urandom_range(0, (avail > 2) ? 2 : avail));
      step(a0, a1, rc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stq_alloc_ctl.md
# stq_alloc_ctl

Store-queue entry lifecycle controller for the 64-entry store-queue address buffer array. Hands out entry indices to the rename stage (tail), strobes one-hot `passe_en` as stores retire, and drains retired stores to the data-cache write port with a valid/ack handshake, pulsing one-hot `free_en` per drained entry. It is the allocation, retire and free driver for the buffer array's per-entry `free`/`passe` state. On exception it reclaims every unretired entry in one cycle.

## Interface
- `BUF_COUNT`, 64: store-queue entries; power of two.
- `PTR_W`, 6: log2(BUF_COUNT); internal pointers are PTR_W+1 bits (wrap bit).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `alloc0_req`  in  1  request one entry.
- `alloc1_req`  in  1  request a second entry; legal only with `alloc0_req`.
- `alloc_ok`  out  1  enough free entries for the requested count; 0 during `excpt`.
- `alloc0_idx`, `alloc1_idx`  out  PTR_W  granted indices: tail, tail+1 (mod BUF_COUNT).
- `retire_cnt`  in  2  stores retiring this cycle, 0..2.
- `passe_en`  out  BUF_COUNT  one-hot/two-hot strobe for retiring entries.
- `drain_valid`  out  1  oldest retired store ready for cache write.
- `drain_idx`  out  PTR_W  entry being drained (head).
- `drain_ack`  in  1  cache accepted the write.
- `free_en`  out  BUF_COUNT  free strobe (drain and flush).
- `excpt`  in  1  pipeline flush.
- `count`  out  PTR_W+1  occupied entries, tail-head.
- `full`, `empty`  out  1  count==BUF_COUNT / count==0.

## Operation
- Three pointers, head ≤ rptr ≤ tail in ring order: [head,rptr) retired awaiting drain, [rptr,tail) allocated unretired.
- Alloc: n = alloc0_req+alloc1_req. `alloc_ok` = (BUF_COUNT-count ≥ n) & ~excpt. If `alloc_ok` is set, tail += n at the edge. Otherwise there is no state change and the requester holds.
- Retire: `passe_en` bits rptr..rptr+retire_cnt-1 are set combinationally, and rptr += retire_cnt. retire_cnt > tail-rptr is illegal; a bench assertion flags it.
- Drain: `drain_valid` = (head != rptr). When drain_valid & drain_ack: free_en[head]=1, head += 1. Maximum one drain per cycle. `drain_idx` stays stable while valid and not acked.
- Flush (`excpt`): retire in the same cycle is applied first, giving rptr'. `free_en` then covers all of [rptr', tail), and tail ← rptr' at the edge. Head and drain are unaffected: retired stores still drain. Drain and flush bits are disjoint and ORed.
- Wrap: all pointer arithmetic is mod 2^(PTR_W+1). Indices use the low PTR_W bits. full ⇔ equal low bits and differing wrap bits.
- Same cycle at full with drain: `alloc_ok` uses pre-edge count, so no same-cycle credit is given for the drain.

## Timing
- Reset: head=rptr=tail=0, count=0, empty=1, full=0, alloc_ok=(n==0 ? 1 : 1), drain_valid=0, passe_en=0, free_en=0, idx outputs=0.
- All outputs are combinational from registered pointers plus current-cycle inputs; strobes are single-cycle. The array updates `passe`/`free` at the same edge the pointers move.
- Allocated entries are visible in `count` one cycle after grant. A retired entry raises `drain_valid` the next cycle; it is never drained in its retire cycle.
- rst mid-operation discards all pointers and emits no free_en strobes. The array resets itself on the same rst.

## Structure
- Package `stq_pkg`: BUF_COUNT, PTR_W, typedef `stq_ptr_t` (PTR_W+1 bits), typedef `stq_vec_t` (BUF_COUNT bits).
- Sub-module `stq_range_mask`: wrapped pointer pair (lo, hi) produces a BUF_COUNT-bit mask of [lo,hi). It is used for the flush mask; the passe/drain one-hots are small decodes.

## Test plan
- Reset, then alloc0+alloc1 for 32 cycles → indices 0..63 in order. Count goes to 64 and full=1. The next request sees alloc_ok=0.
- From full, retire_cnt=2 → passe_en = bits 0 and 1. Next cycle drain_valid=1, drain_idx=0. Hold drain_ack=0 for 3 cycles → idx stable. Ack → free_en bit 0, count=63.
- Wrap: after draining 0..3, alloc 2 → indices 0,1 (wrap bit toggled). full=0, count=62.
- Flush: tail=10, rptr=4, head=2, excpt with retire_cnt=1 → passe_en bit 4 and free_en bits 5..9 in one cycle. Then tail=5, and drain continues from 2.
- Flush with drain_ack the same cycle, head=2, rptr=4, tail=6 → free_en bits 2,4,5. Head=3, tail=4.
- Reset asserted while drain_valid=1 and count=20 → next cycle count=0, empty=1, all strobes 0.
